fractal_core_pool: RTL and testbench

//  Pool of CORE_COUNT escape-time iterator lanes behind one job queue port and one result port.

---
 rtl/fractal_core_pool.sv | 161 ++++++++++++++++
 tb/tb_fractal_core_pool.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_core_pool.sv
// Pool of escape-time iterator lanes shared by Mandelbrot and Julia jobs.
// One job queue port feeds the lowest free lane; a round-robin arbiter returns tagged counts.
module fractal_core_pool #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int CORE_COUNT      = 16,
    parameter int TAG_WIDTH       = 16,
    localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         job_valid_i,
    output logic                         job_ready_o,
    input  logic                         job_mode_i,
    input  logic signed [DATA_WIDTH-1:0] job_x_i,
    input  logic signed [DATA_WIDTH-1:0] job_y_i,
    input  logic [TAG_WIDTH-1:0]         job_tag_i,
    input  logic signed [DATA_WIDTH-1:0] cx_i,
    input  logic signed [DATA_WIDTH-1:0] cy_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]    res_iter_o,
    output logic [TAG_WIDTH-1:0]         res_tag_o,
    output logic                         busy_o
);

    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam int PTR_W  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam logic signed [PROD_W-1:0] ESCAPE_LIMIT = PROD_W'(4) << (2 * FRACTIONAL_BITS);

    typedef enum logic [1:0] {LANE_IDLE, LANE_ITER, LANE_DONE} laneState_t;

    laneState_t                    r_state   [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  r_zx      [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  r_zy      [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  r_cx      [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  r_cy      [CORE_COUNT];
    logic [MAX_ITER_WIDTH-1:0]     r_iter    [CORE_COUNT];
    logic [MAX_ITER_WIDTH-1:0]     r_maxIter [CORE_COUNT];
    logic [TAG_WIDTH-1:0]          r_tag     [CORE_COUNT];

    logic                          r_resValid;
    logic [MAX_ITER_WIDTH-1:0]     r_resIter;
    logic [TAG_WIDTH-1:0]          r_resTag;
    logic [PTR_W-1:0]              r_rrPtr;

    logic signed [PROD_W-1:0]      w_zx2     [CORE_COUNT];
    logic signed [PROD_W-1:0]      w_zy2     [CORE_COUNT];
    logic signed [PROD_W-1:0]      w_mag     [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  w_nextZx  [CORE_COUNT];
    logic signed [DATA_WIDTH-1:0]  w_nextZy  [CORE_COUNT];
    logic [CORE_COUNT-1:0]         w_finish;
    logic [CORE_COUNT-1:0]         w_idle;
    logic [CORE_COUNT-1:0]         w_done;
    logic [CORE_COUNT-1:0]         w_dispSel;
    logic [CORE_COUNT-1:0]         w_grantSel;
    logic [PTR_W-1:0]              w_grantIdx;
    logic                          w_anyDone;
    logic                          w_accept;
    logic                          w_load;

    // Full-precision products: the escape compare must never see a truncated magnitude.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            w_zx2[i]    = PROD_W'(r_zx[i]) * PROD_W'(r_zx[i]);
            w_zy2[i]    = PROD_W'(r_zy[i]) * PROD_W'(r_zy[i]);
            w_mag[i]    = w_zx2[i] + w_zy2[i];
            w_nextZx[i] = DATA_WIDTH'((w_zx2[i] - w_zy2[i]) >>> FRACTIONAL_BITS) + r_cx[i];
            w_nextZy[i] = DATA_WIDTH'(((PROD_W'(r_zx[i]) * PROD_W'(r_zy[i])) <<< 1)
                                      >>> FRACTIONAL_BITS) + r_cy[i];
            w_finish[i] = (w_mag[i] > ESCAPE_LIMIT) || (r_iter[i] == r_maxIter[i]);
            w_idle[i]   = (r_state[i] == LANE_IDLE);
            w_done[i]   = (r_state[i] == LANE_DONE);
        end
    end

    always_comb begin
        logic seen;
        seen      = 1'b0;
        w_dispSel = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            w_dispSel[i] = w_idle[i] && !seen;
            seen         = seen || w_idle[i];
        end
    end

    // Search starts at the round-robin pointer so no DONE lane can be starved.
    always_comb begin
        int idx;
        w_anyDone  = 1'b0;
        w_grantIdx = '0;
        w_grantSel = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            idx = (int'(r_rrPtr) + k) % CORE_COUNT;
            if (!w_anyDone && w_done[idx]) begin
                w_anyDone       = 1'b1;
                w_grantIdx      = PTR_W'(idx);
                w_grantSel[idx] = 1'b1;
            end
        end
    end

    assign job_ready_o = |w_idle;
    assign w_accept    = job_valid_i && job_ready_o;
    assign w_load      = w_anyDone && (!r_resValid || res_ready_i);
    assign res_valid_o = r_resValid;
    assign res_iter_o  = r_resIter;
    assign res_tag_o   = r_resTag;
    assign busy_o      = !(&w_idle) || r_resValid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                r_state[i] <= LANE_IDLE;
            end
            r_resValid <= 1'b0;
            r_resIter  <= '0;
            r_resTag   <= '0;
            r_rrPtr    <= '0;
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                case (r_state[i])
                    LANE_IDLE: if (w_accept && w_dispSel[i]) r_state[i] <= LANE_ITER;
                    LANE_ITER: if (w_finish[i])              r_state[i] <= LANE_DONE;
                    LANE_DONE: if (w_load && w_grantSel[i])  r_state[i] <= LANE_IDLE;
                    default:                                 r_state[i] <= LANE_IDLE;
                endcase
            end
            if (w_load) begin
                r_resValid <= 1'b1;
                r_resIter  <= r_iter[w_grantIdx];
                r_resTag   <= r_tag[w_grantIdx];
                r_rrPtr    <= (int'(w_grantIdx) == CORE_COUNT - 1) ? '0 : w_grantIdx + 1'b1;
            end else if (res_ready_i) begin
                r_resValid <= 1'b0;
            end
        end
    end

    // Mode only steers the initial load; after that every lane runs the same recurrence.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (w_accept && w_dispSel[i]) begin
                r_zx[i]      <= job_mode_i ? job_x_i : '0;
                r_zy[i]      <= job_mode_i ? job_y_i : '0;
                r_cx[i]      <= job_mode_i ? cx_i : job_x_i;
                r_cy[i]      <= job_mode_i ? cy_i : job_y_i;
                r_iter[i]    <= '0;
                r_maxIter[i] <= max_iter_i;
                r_tag[i]     <= job_tag_i;
            end else if (r_state[i] == LANE_ITER && !w_finish[i]) begin
                r_zx[i]   <= w_nextZx[i];
                r_zy[i]   <= w_nextZy[i];
                r_iter[i] <= r_iter[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fractal_core_pool.sv
// Directed bench for fractal_core_pool: latency, escape boundaries, ordering,
// backpressure with a full pool, and reset while busy.
module tb_fractal_core_pool;

    localparam int F = 24;

    localparam logic signed [31:0] ONE     = 32'sh0100_0000;
    localparam logic signed [31:0] TWO     = 32'sh0200_0000;
    localparam logic signed [31:0] NEG_TWO = -32'sh0200_0000;
    localparam logic signed [31:0] HALF    = 32'sh0080_0000;
    localparam logic signed [31:0] NEG_3Q  = -32'sh00C0_0000;
    localparam logic signed [31:0] TENTH   = 32'sd1677722;

    logic               clk = 1'b0;
    logic               rst;
    logic               jobValid;
    logic               jobReady;
    logic               jobMode;
    logic signed [31:0] jobX;
    logic signed [31:0] jobY;
    logic [15:0]        jobTag;
    logic signed [31:0] cx;
    logic signed [31:0] cy;
    logic [15:0]        maxIter;
    logic               resValid;
    logic               resReady;
    logic [15:0]        resIter;
    logic [15:0]        resTag;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fractal_core_pool #(
        .INTEGER_BITS(8), .FRACTIONAL_BITS(F), .MAX_ITER_WIDTH(16),
        .CORE_COUNT(16), .TAG_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(jobValid), .job_ready_o(jobReady), .job_mode_i(jobMode),
        .job_x_i(jobX), .job_y_i(jobY), .job_tag_i(jobTag),
        .cx_i(cx), .cy_i(cy), .max_iter_i(maxIter),
        .res_valid_o(resValid), .res_ready_i(resReady),
        .res_iter_o(resIter), .res_tag_o(resTag), .busy_o(busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic applyStimulus(input logic mode, input logic signed [31:0] x,
                                 input logic signed [31:0] y, input logic signed [31:0] jcx,
                                 input logic signed [31:0] jcy, input logic [15:0] lim,
                                 input logic [15:0] tag);
        int n = 0;
        jobMode = mode; jobX = x; jobY = y; cx = jcx; cy = jcy; maxIter = lim; jobTag = tag;
        jobValid = 1'b1;
        while (!jobReady && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checkOutput("accept_timeout", 64'(n), 64'(0));
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        jobValid = 1'b0;
    endtask

    task automatic getResult(output logic [15:0] it, output logic [15:0] tg, output logic ok);
        int n = 0;
        ok = 1'b0; it = '0; tg = '0;
        while (!resValid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (resValid) begin
            it = resIter; tg = resTag; ok = 1'b1;
            resReady = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resReady = 1'b0;
        end
    endtask

    // Independent fixed-point reference for the escape-time recurrence.
    function automatic int modelIter(input int zx0, input int zy0, input int ccx,
                                     input int ccy, input int lim);
        longint zx = zx0, zy = zy0, sx, sy;
        int nzx, nzy;
        for (int it = 0; it <= lim; it++) begin
            sx = zx * zx;
            sy = zy * zy;
            if (sx + sy > (longint'(4) <<< (2 * F))) return it;
            if (it == lim) return it;
            nzx = int'((sx - sy) >>> F) + ccx;
            nzy = int'((2 * zx * zy) >>> F) + ccy;
            zx = nzx;
            zy = nzy;
        end
        return lim;
    endfunction

    initial begin
        logic [15:0] it, tg, it0, tg0;
        logic        ok;
        logic [15:0] seen;
        int          n, cnt, bad, dup, juliaExp;

        rst = 1'b1; jobValid = 1'b0; jobMode = 1'b0; jobX = '0; jobY = '0; jobTag = '0;
        cx = '0; cy = '0; maxIter = '0; resReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_res_valid", 64'(resValid), 64'(0));
        checkOutput("rst_res_iter", 64'(resIter), 64'(0));
        checkOutput("rst_res_tag", 64'(resTag), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_job_ready", 64'(jobReady), 64'(1));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] Mandelbrot origin, latency");
        applyStimulus(1'b0, 0, 0, 0, 0, 16'd100, 16'd7);
        n = 0;
        while (!resValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1_latency", 64'(n), 64'(102));
        getResult(it, tg, ok);
        checkOutput("t1_got", 64'(ok), 64'(1));
        checkOutput("t1_iter", 64'(it), 64'(100));
        checkOutput("t1_tag", 64'(tg), 64'(7));

        $display("[TB] Fast escapes");
        applyStimulus(1'b0, TWO, TWO, 0, 0, 16'd50, 16'd11);
        getResult(it, tg, ok);
        checkOutput("t2_mandel_iter", 64'(it), 64'(1));
        checkOutput("t2_mandel_tag", 64'(tg), 64'(11));
        applyStimulus(1'b1, TWO, TWO, 0, 0, 16'd50, 16'd12);
        getResult(it, tg, ok);
        checkOutput("t2_julia_iter", 64'(it), 64'(0));
        checkOutput("t2_julia_tag", 64'(tg), 64'(12));

        $display("[TB] Boundary cases");
        applyStimulus(1'b0, 0, 0, 0, 0, 16'd0, 16'd20);
        getResult(it, tg, ok);
        checkOutput("maxiter0_iter", 64'(it), 64'(0));
        applyStimulus(1'b0, TWO, 0, 0, 0, 16'd20, 16'd21);
        getResult(it, tg, ok);
        checkOutput("mag_eq4_then_escape", 64'(it), 64'(2));
        applyStimulus(1'b0, NEG_TWO, 0, 0, 0, 16'd20, 16'd22);
        getResult(it, tg, ok);
        checkOutput("mag_eq4_bounded", 64'(it), 64'(20));
        applyStimulus(1'b1, 0, 0, NEG_TWO, 0, 16'd10, 16'd40);
        cx = ONE; cy = ONE; maxIter = 16'd3;
        getResult(it, tg, ok);
        checkOutput("julia_const_latched_iter", 64'(it), 64'(10));
        checkOutput("julia_const_latched_tag", 64'(tg), 64'(40));

        $display("[TB] Out-of-order return");
        juliaExp = modelIter(0, 0, NEG_3Q, TENTH, 255);
        checkOutput("t3_model_range", 64'(juliaExp >= 20 && juliaExp <= 60), 64'(1));
        applyStimulus(1'b1, 0, 0, NEG_3Q, TENTH, 16'd255, 16'd31);
        applyStimulus(1'b0, HALF, HALF, 0, 0, 16'd255, 16'd32);
        getResult(it, tg, ok);
        checkOutput("t3_first_tag", 64'(tg), 64'(32));
        checkOutput("t3_first_iter", 64'(it), 64'(5));
        getResult(it, tg, ok);
        checkOutput("t3_second_tag", 64'(tg), 64'(31));
        checkOutput("t3_second_iter", 64'(it), 64'(juliaExp));

        $display("[TB] Full pool and backpressure");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 0, 16'd1000, 16'(100 + i));
        end
        cnt = 0;
        for (int c = 0; c < 900; c++) begin
            if (jobReady) cnt++;
            @(negedge clk);
        end
        checkOutput("t4_ready_low_cycles", 64'(cnt), 64'(0));
        n = 0;
        while (!resValid && n < 300) begin
            @(negedge clk);
            n++;
        end
        it0 = resIter; tg0 = resTag;
        checkOutput("t4_first_valid", 64'(resValid), 64'(1));
        checkOutput("t4_first_tag", 64'(tg0), 64'(100));
        checkOutput("t4_first_iter", 64'(it0), 64'(1000));
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (resValid !== 1'b1 || resIter !== it0 || resTag !== tg0) bad++;
        end
        checkOutput("t4_hold_stable", 64'(bad), 64'(0));
        seen = '0; bad = 0; dup = 0; cnt = 0;
        resReady = 1'b1;
        for (int c = 0; c < 200 && cnt < 16; c++) begin
            if (resValid) begin
                if (resTag < 16'd100 || resTag > 16'd115) bad++;
                else if (seen[resTag - 16'd100]) dup++;
                else seen[resTag - 16'd100] = 1'b1;
                if (resIter !== 16'd1000) bad++;
                cnt++;
            end
            @(negedge clk);
        end
        resReady = 1'b0;
        checkOutput("t4_tags_seen", 64'(seen), 64'(16'hFFFF));
        checkOutput("t4_dups", 64'(dup), 64'(0));
        checkOutput("t4_bad_results", 64'(bad), 64'(0));

        $display("[TB] Reset while busy");
        applyStimulus(1'b0, 0, 0, 0, 0, 16'd0, 16'd200);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 0, 16'd1000, 16'(201 + i));
        end
        n = 0;
        while (!resValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_pre_valid", 64'(resValid), 64'(1));
        checkOutput("t6_pre_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_res_valid", 64'(resValid), 64'(0));
        checkOutput("t6_busy", 64'(busy), 64'(0));
        checkOutput("t6_job_ready", 64'(jobReady), 64'(1));
        resReady = 1'b1;
        cnt = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (resValid || busy) cnt++;
        end
        resReady = 1'b0;
        checkOutput("t6_no_stale", 64'(cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
